// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Purpose  : Sequences CPU reset/ready/run with timeouts and logs OutReg changes.
// Revision : 1.0
// ============================================================================
module cpu_run_controller #(
  parameter int DataWidth    = 16,
  parameter int ResetCycles  = 2,
  parameter int ReadyTimeout = 64,
  parameter int RunTimeout   = 50000,
  parameter int CntWidth     = 16,
  parameter int LogDepth     = 8
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Ready,
  input  logic                        Halt,
  input  logic [DataWidth-1:0]        OutReg,
  output logic                        CpuReset_n,
  output logic                        Busy,
  output logic                        Done,
  output logic [1:0]                  Status,
  output logic [CntWidth-1:0]         CycleCount,
  input  logic                        LogRdEn,
  output logic [DataWidth-1:0]        LogRdData,
  output logic                        LogEmpty,
  output logic [$clog2(LogDepth):0]   LogCount,
  output logic                        LogOverflow
);

  localparam int AW        = $clog2(LogDepth);
  localparam int CW        = AW + 1;
  localparam int PHASE_MAX = (ResetCycles > ReadyTimeout) ? ResetCycles : ReadyTimeout;
  localparam int PW        = $clog2(PHASE_MAX + 1);

  localparam logic [PW-1:0]       c_RST_LAST = PW'(ResetCycles - 1);
  localparam logic [PW-1:0]       c_RDY_LAST = PW'(ReadyTimeout - 1);
  localparam logic [CntWidth-1:0] c_RUN_LAST = CntWidth'(RunTimeout - 1);
  localparam logic [CW-1:0]       c_DEPTH    = CW'(LogDepth);

  typedef enum logic [2:0] {
    S_Idle      = 3'd0,
    S_Reset     = 3'd1,
    S_WaitReady = 3'd2,
    S_Run       = 3'd3,
    S_Done      = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic [PW-1:0]         r_phase;
  logic [CntWidth-1:0]   r_cycle_count;
  logic [1:0]            r_status;
  logic                  r_done;
  logic [DataWidth-1:0]  r_snap;
  logic [DataWidth-1:0]  r_mem [LogDepth];
  logic [AW-1:0]         r_wr, r_rd;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;

  logic       w_accept, w_phase_clr, w_phase_inc, w_cnt_inc, w_finish, w_snap_load;
  logic [1:0] w_status;
  logic       w_push, w_pop, w_full, w_push_ok;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_Idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_phase_clr = 1'b0;
    w_phase_inc = 1'b0;
    w_cnt_inc   = 1'b0;
    w_finish    = 1'b0;
    w_status    = 2'd0;
    w_snap_load = 1'b0;
    case (r_state)
      S_Idle, S_Done: begin
        if (Start) begin
          w_accept    = 1'b1;
          w_phase_clr = 1'b1;
          w_next      = S_Reset;
        end
      end
      S_Reset: begin
        if (r_phase == c_RST_LAST) begin
          w_phase_clr = 1'b1;
          w_next      = S_WaitReady;
        end else begin
          w_phase_inc = 1'b1;
        end
      end
      S_WaitReady: begin
        if (Ready) begin
          w_snap_load = 1'b1;
          w_next      = S_Run;
        end else if (r_phase == c_RDY_LAST) begin
          w_finish = 1'b1;
          w_status = 2'd3;
          w_next   = S_Done;
        end else begin
          w_phase_inc = 1'b1;
        end
      end
      S_Run: begin
        // Halt is checked first so it wins over a coincident timeout.
        if (Halt) begin
          w_finish = 1'b1;
          w_status = 2'd1;
          w_next   = S_Done;
        end else if (r_cycle_count == c_RUN_LAST) begin
          w_finish = 1'b1;
          w_status = 2'd2;
          w_next   = S_Done;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_next = S_Idle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_phase       <= '0;
      r_cycle_count <= '0;
      r_status      <= 2'd0;
      r_done        <= 1'b0;
      r_snap        <= '0;
    end else begin
      r_done <= w_finish;
      if (w_phase_clr)      r_phase <= '0;
      else if (w_phase_inc) r_phase <= r_phase + PW'(1);
      if (w_accept)       r_cycle_count <= '0;
      else if (w_cnt_inc) r_cycle_count <= r_cycle_count + CntWidth'(1);
      if (w_accept)      r_status <= 2'd0;
      else if (w_finish) r_status <= w_status;
      if (w_snap_load || w_push) r_snap <= OutReg;
    end
  end

  assign w_push    = (r_state == S_Run) && (OutReg != r_snap);
  assign w_pop     = LogRdEn && (r_count != '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_push_ok = w_push && (!w_full || w_pop);

  always_ff @(posedge Clk) begin
    if (w_push_ok) r_mem[r_wr] <= OutReg;
  end

  always_ff @(posedge Clk) begin
    if (Reset || w_accept) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop)     r_rd <= r_rd + AW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - CW'(1);
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  assign CpuReset_n  = (r_state == S_WaitReady) || (r_state == S_Run) || (r_state == S_Done);
  assign Busy        = (r_state == S_Reset) || (r_state == S_WaitReady) || (r_state == S_Run);
  assign Done        = r_done;
  assign Status      = r_status;
  assign CycleCount  = r_cycle_count;
  assign LogEmpty    = (r_count == '0);
  assign LogCount    = r_count;
  assign LogOverflow = r_overflow;
  assign LogRdData   = LogEmpty ? '0 : r_mem[r_rd];

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_controller
// Purpose  : Directed self-checking bench for cpu_run_controller.
// Revision : 1.0
// ============================================================================
module tb_cpu_run_controller;

  logic        Clk, Reset, Start, Ready, Halt, LogRdEn;
  logic [15:0] OutReg;
  logic        CpuReset_n, Busy, Done, LogEmpty, LogOverflow;
  logic [1:0]  Status;
  logic [15:0] CycleCount, LogRdData;
  logic [3:0]  LogCount;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_controller #(
    .DataWidth(16), .ResetCycles(2), .ReadyTimeout(64),
    .RunTimeout(50), .CntWidth(16), .LogDepth(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ready(Ready), .Halt(Halt),
    .OutReg(OutReg), .CpuReset_n(CpuReset_n), .Busy(Busy), .Done(Done),
    .Status(Status), .CycleCount(CycleCount), .LogRdEn(LogRdEn),
    .LogRdData(LogRdData), .LogEmpty(LogEmpty), .LogCount(LogCount),
    .LogOverflow(LogOverflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Pulses Start and returns how many sampled cycles CpuReset_n stayed low.
  task automatic do_start(output int n_low);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_low = 0;
    while (CpuReset_n == 1'b0 && n_low < 10) begin
      n_low++;
      tick();
    end
  endtask

  task automatic pop_one;
    LogRdEn = 1'b1;
    tick();
    LogRdEn = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    n_checks++;
    if ({CpuReset_n, Busy, Done, Status, LogEmpty, LogOverflow} !== 7'b0000010) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000010",
               {CpuReset_n, Busy, Done, Status, LogEmpty, LogOverflow});
    end
    n_checks++;
    if ({CycleCount, LogCount, LogRdData} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_values: cc=%0d cnt=%0d rd=%0h expected all 0", CycleCount, LogCount, LogRdData);
    end
  endtask

  task automatic test_normal_run;
    int n_low;
    do_start(n_low);
    for (int i = 0; i < 3; i++) tick();
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    n_checks++;
    if ({Busy, CpuReset_n, CycleCount} !== {2'b11, 16'd0}) begin
      n_fail++;
      $display("FAIL normal_run_entry: busy=%b rstn=%b cc=%0d expected 1 1 0", Busy, CpuReset_n, CycleCount);
    end
    for (int k = 0; k < 20; k++) begin
      if (k == 3)  OutReg = 16'd5;
      if (k == 10) OutReg = 16'd9;
      tick();
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    n_checks++;
    if ({Done, Status, Busy, CpuReset_n} !== 5'b10101) begin
      n_fail++;
      $display("FAIL normal_done: done/status/busy/rstn got %b expected 10101", {Done, Status, Busy, CpuReset_n});
    end
    n_checks++;
    if (CycleCount !== 16'd20) begin
      n_fail++;
      $display("FAIL normal_cycles: got %0d expected 20", CycleCount);
    end
    tick();
    n_checks++;
    if (Done !== 1'b0 || Status !== 2'd1) begin
      n_fail++;
      $display("FAIL normal_done_pulse: done=%b status=%0d expected 0 1", Done, Status);
    end
    n_checks++;
    if (LogCount !== 4'd2 || LogRdData !== 16'd5) begin
      n_fail++;
      $display("FAIL normal_log_first: cnt=%0d data=%0d expected 2 5", LogCount, LogRdData);
    end
    pop_one();
    n_checks++;
    if (LogRdData !== 16'd9) begin
      n_fail++;
      $display("FAIL normal_log_second: got %0d expected 9", LogRdData);
    end
    pop_one();
    n_checks++;
    if (LogEmpty !== 1'b1 || LogRdData !== 16'd0) begin
      n_fail++;
      $display("FAIL normal_log_empty: empty=%b data=%0h expected 1 0", LogEmpty, LogRdData);
    end
    // Restart from S_Done, where CpuReset_n was high, to measure the reset pulse.
    do_start(n_low);
    n_checks++;
    if (n_low !== 2) begin
      n_fail++;
      $display("FAIL reset_pulse_width: got %0d expected 2", n_low);
    end
  endtask

  task automatic test_runaway;
    int cyc;
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    cyc = 0;
    while (!Done && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 50) begin
      n_fail++;
      $display("FAIL runaway_latency: got %0d expected 50", cyc);
    end
    n_checks++;
    if ({Status, CycleCount, CpuReset_n} !== {2'd2, 16'd49, 1'b1}) begin
      n_fail++;
      $display("FAIL runaway_result: status=%0d cc=%0d rstn=%b expected 2 49 1", Status, CycleCount, CpuReset_n);
    end
    tick();
    n_checks++;
    if (Done !== 1'b0 || CpuReset_n !== 1'b1) begin
      n_fail++;
      $display("FAIL runaway_after: done=%b rstn=%b expected 0 1", Done, CpuReset_n);
    end
  endtask

  task automatic test_ready_never;
    int n_low, cyc;
    do_start(n_low);
    cyc = 0;
    while (!Done && cyc < 200) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 64) begin
      n_fail++;
      $display("FAIL ready_timeout_latency: got %0d expected 64", cyc);
    end
    n_checks++;
    if ({Status, CycleCount, LogEmpty, Busy} !== {2'd3, 16'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ready_timeout_result: status=%0d cc=%0d empty=%b busy=%b expected 3 0 1 0",
               Status, CycleCount, LogEmpty, Busy);
    end
  endtask

  task automatic test_log_overflow;
    int n_low;
    logic [15:0] exp_q [8];
    do_start(n_low);
    OutReg = 16'd0;
    Ready  = 1'b1;
    tick();
    Ready  = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      OutReg = 16'(i * 3);
      tick();
    end
    n_checks++;
    if ({LogCount, LogOverflow, LogRdData} !== {4'd8, 1'b1, 16'd3}) begin
      n_fail++;
      $display("FAIL overflow_state: cnt=%0d ovf=%b head=%0d expected 8 1 3", LogCount, LogOverflow, LogRdData);
    end
    OutReg  = 16'd100;
    LogRdEn = 1'b1;
    tick();
    LogRdEn = 1'b0;
    n_checks++;
    if (LogCount !== 4'd8) begin
      n_fail++;
      $display("FAIL full_push_pop_count: got %0d expected 8", LogCount);
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    for (int i = 0; i < 7; i++) exp_q[i] = 16'((i + 2) * 3);
    exp_q[7] = 16'd100;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (LogRdData !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overflow_read_%0d: got %0d expected %0d", i, LogRdData, exp_q[i]);
      end
      pop_one();
    end
    n_checks++;
    if (LogEmpty !== 1'b1 || LogCount !== 4'd0) begin
      n_fail++;
      $display("FAIL overflow_drained: empty=%b cnt=%0d expected 1 0", LogEmpty, LogCount);
    end
  endtask

  task automatic test_simultaneous;
    int n_low;
    do_start(n_low);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    for (int k = 0; k < 49; k++) begin
      Start = (k == 10);
      tick();
      if (k == 10) begin
        n_checks++;
        if (Busy !== 1'b1 || CycleCount !== 16'd11) begin
          n_fail++;
          $display("FAIL start_while_busy: busy=%b cc=%0d expected 1 11", Busy, CycleCount);
        end
      end
    end
    Start  = 1'b0;
    Halt   = 1'b1;
    OutReg = 16'h0077;
    tick();
    Halt   = 1'b0;
    n_checks++;
    if ({Done, Status, CycleCount} !== {1'b1, 2'd1, 16'd49}) begin
      n_fail++;
      $display("FAIL halt_vs_timeout: done=%b status=%0d cc=%0d expected 1 1 49", Done, Status, CycleCount);
    end
    n_checks++;
    if (LogCount !== 4'd1 || LogRdData !== 16'h0077) begin
      n_fail++;
      $display("FAIL halt_cycle_log: cnt=%0d data=%0h expected 1 77", LogCount, LogRdData);
    end
  endtask

  task automatic test_reset_mid_run;
    int n_low;
    do_start(n_low);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    OutReg = 16'h0011;
    tick();
    OutReg = 16'h0022;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks++;
    if ({CpuReset_n, Busy, Done, Status, LogEmpty, LogOverflow, CycleCount, LogCount, LogRdData}
        !== {7'b0000010, 36'd0}) begin
      n_fail++;
      $display("FAIL mid_run_reset: rstn=%b busy=%b done=%b st=%0d empty=%b cc=%0d cnt=%0d expected 0 0 0 0 1 0 0",
               CpuReset_n, Busy, Done, Status, LogEmpty, CycleCount, LogCount);
    end
    do_start(n_low);
    n_checks++;
    if (n_low !== 2 || LogEmpty !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_restart: low=%0d empty=%b expected 2 1", n_low, LogEmpty);
    end
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    OutReg = 16'h0033;
    for (int k = 0; k < 4; k++) tick();
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    n_checks++;
    if ({Status, CycleCount, LogCount, LogRdData} !== {2'd1, 16'd4, 4'd1, 16'h0033}) begin
      n_fail++;
      $display("FAIL clean_run_result: st=%0d cc=%0d cnt=%0d data=%0h expected 1 4 1 33",
               Status, CycleCount, LogCount, LogRdData);
    end
  endtask

  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    Ready   = 1'b0;
    Halt    = 1'b0;
    LogRdEn = 1'b0;
    OutReg  = 16'd0;
    test_reset();
    test_normal_run();
    test_runaway();
    test_ready_never();
    test_log_overflow();
    test_simultaneous();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synthesizable run controller that wraps the CPU and replaces hand-timed bench sequencing with hardware sequencing.
- On `Start`: pulses the CPU reset, waits for `Ready`, runs the CPU while counting cycles, and stops on `Halt` or on a programmable runaway timeout.
- Every change of the CPU output register is logged into a readable FIFO.
- Sits between the top-level/bench and the CPU core, so benches and the FPGA top share one run/timeout/capture mechanism.

## Interface
Parameters:
- DataWidth, 16, width of CPU `OutReg` and log entries
- ResetCycles, 2, cycles `CpuReset_n` is held low per run (>=1)
- ReadyTimeout, 64, max cycles waiting for `Ready` after CPU reset release
- RunTimeout, 50000, max run cycles before timeout; must be < 2^CntWidth
- CntWidth, 16, width of `CycleCount`
- LogDepth, 8, log FIFO depth; power of two, >=2

Ports:
- Clk  in  1  clock; all logic on rising edge
- Reset  in  1  reset; one clock, synchronous and active-high
- Start  in  1  begin a run; sampled only in S_Idle/S_Done
- Ready  in  1  CPU ready
- Halt  in  1  CPU halt
- OutReg  in  DataWidth  CPU output register
- CpuReset_n  out  1  active-low reset to CPU
- Busy  out  1  high in S_Reset, S_WaitReady, S_Run
- Done  out  1  one-cycle pulse on entry to S_Done
- Status  out  2  0 none, 1 halted, 2 run timeout, 3 ready timeout
- CycleCount  out  CntWidth  run cycles counted in S_Run
- LogRdEn  in  1  pop log head
- LogRdData  out  DataWidth  log head (valid when !LogEmpty)
- LogEmpty  out  1  log empty
- LogCount  out  log2(LogDepth)+1  entries held
- LogOverflow  out  1  sticky: an entry was dropped

## Operation
- Reset values: state S_Idle, CpuReset_n=0, Busy=0, Done=0, Status=0, CycleCount=0, log empty, LogCount=0, LogOverflow=0, LogRdData=0.
- **S_Idle**: CPU is held in reset.
  - `Start` → S_Reset.
  - On the accept cycle: clear CycleCount, Status, the log and LogOverflow.
- **S_Reset**: CpuReset_n=0 for exactly ResetCycles cycles, then → S_WaitReady.
- **S_WaitReady**: CpuReset_n=1.
  - `Ready` → S_Run; the snapshot register loads OutReg.
  - ReadyTimeout cycles without `Ready` → S_Done, Status=3.
- **S_Run**: CycleCount increments by 1 each cycle.
  - `Halt` → S_Done, Status=1.
  - CycleCount==RunTimeout-1 with no `Halt` → S_Done, Status=2.
  - If Halt and timeout occur in the same cycle, Halted wins.
- **S_Done**: CpuReset_n stays 1, so CPU state remains inspectable. Status and CycleCount hold.
  - `Start` → same as in S_Idle (clear, then S_Reset).
- `Start` is ignored while Busy.
- **Log capture** (S_Run only): when OutReg != snapshot, push OutReg and update the snapshot.
  - A change on the Halt cycle is still logged.
- **Log FIFO**:
  - Full and push without a pop: the entry is dropped and LogOverflow is set.
  - Push and pop in the same cycle while non-empty: both take effect, count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo LogDepth.
- The log stays readable in S_Done and S_Idle until the next accepted `Start`.
- `Reset` mid-run: immediate return to reset values; the CPU is re-held in reset the next cycle.

## Timing
- `Start` sampled at edge T → state is S_Reset from T+1, and CpuReset_n=0 for edges T+1..T+ResetCycles.
- CpuReset_n=1 from edge T+ResetCycles+1.
- `Ready` high at edge R → state is S_Run from R+1; the first CycleCount increment is at R+2.
- `Halt` sampled at edge H → Done=1 and Status valid after H+1. Done drops after H+2.
- CycleCount equals the number of S_Run cycles, excluding the exit cycle.
- Log push visible one cycle after the changed OutReg is sampled.
- LogRdData is first-word-fall-through: the head is combinational from storage. `LogRdEn` advances the head at the edge.

## Test plan
- **Normal run**: ResetCycles=2. Start pulse, Ready after 3 cycles, OutReg 0→5→9, Halt after 20 run cycles.
  - Required: CpuReset_n low exactly 2 cycles; Status=1; Done one pulse; CycleCount=20; log reads 5 then 9, then LogEmpty.
- **Runaway**: RunTimeout=50, Halt never asserted.
  - Required: Status=2; CycleCount=49; Done pulses once; CpuReset_n stays 1.
- **Ready never**: ReadyTimeout=64, Ready held low.
  - Required: Status=3 after 64 cycles in S_WaitReady; CycleCount=0; log empty.
- **Log overflow**: LogDepth=8, 10 distinct OutReg changes, no reads.
  - Required: LogCount=8; LogOverflow=1; reads return the first 8 values in order.
  - A push+pop in the same cycle when full keeps LogCount=8.
- **Simultaneous events**:
  - Halt on the same cycle as the timeout → Status=1.
  - OutReg change on the Halt cycle → that value is logged.
  - Start while Busy → ignored (state and CycleCount unaffected).
- **Reset mid-run**: assert Reset for 1 cycle during S_Run.
  - Required: all outputs at reset values next cycle; CpuReset_n=0.
  - A subsequent Start performs a clean run with a cleared log.
